cmd_encoder: RTL and testbench

CMD_ENCODER -- requirements
Module: cmd_encoder

---
 rtl/cmd_encoder_if.sv | 24 ++
 rtl/cmd_encoder.sv | 148 ++++++++++++++
 tb/tb_cmd_encoder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_encoder_if.sv
// Request/UART handshake bundle for cmd_encoder.
// The testbench drives the master side and the encoder is the slave.
interface cmd_encoder_if;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] src1;
   logic [7:0] src2;
   logic [4:0] operator;
   logic [3:0] data_type;
   logic       uin_ready;
   logic [7:0] uart_out;
   logic       uout_valid;
   logic       cmd_done;

   modport master (
      output req_valid, src1, src2, operator, data_type, uin_ready,
      input  req_ready, uart_out, uout_valid, cmd_done
   );

   modport slave (
      input  req_valid, src1, src2, operator, data_type, uin_ready,
      output req_ready, uart_out, uout_valid, cmd_done
   );
endinterface

// File: rtl/cmd_encoder.sv
// Formats "src1 op src2<eol>" as an ASCII byte stream in hex or decimal.
// Define CMD_ENCODER_CRLF_EN to end each frame with CR LF instead of LF.
module cmd_encoder (
   input  logic         clk,
   input  logic         n_rst,
   cmd_encoder_if.slave bus
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

`ifdef CMD_ENCODER_CRLF_EN
   localparam int EOL_LEN = 2;
`else
   localparam int EOL_LEN = 1;
`endif
   localparam logic [3:0] HEX_LAST = 4'(6 + EOL_LEN);
   localparam logic [3:0] DEC_LAST = 4'(8 + EOL_LEN);

   logic [0:0] state_q;
   logic [3:0] idx_q;
   logic       valid_q;
   logic       done_q;
   logic       ready_q;
   logic [7:0] s1_q;
   logic [7:0] s2_q;
   logic [4:0] op_q;
   logic       dec_q;

   logic [7:0] frame [0:15];
   logic [7:0] op_char;
   logic [3:0] last_idx;
   logic [3:0] eol_pos;
   logic [7:0] s1_hun, s1_ten, s1_one;
   logic [7:0] s2_hun, s2_ten, s2_one;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction

   // Digit extraction works only from the captured operands, never the live inputs.
   assign s1_hun = s1_q / 8'd100;
   assign s1_ten = (s1_q / 8'd10) % 8'd10;
   assign s1_one = s1_q % 8'd10;
   assign s2_hun = s2_q / 8'd100;
   assign s2_ten = (s2_q / 8'd10) % 8'd10;
   assign s2_one = s2_q % 8'd10;

   assign last_idx = dec_q ? DEC_LAST : HEX_LAST;

   always_comb begin
      case (op_q)
         5'd0:    op_char = 8'h2B;
         5'd1:    op_char = 8'h2D;
         5'd2:    op_char = 8'h2A;
         5'd3:    op_char = 8'h2F;
         5'd4:    op_char = 8'h26;
         5'd5:    op_char = 8'h7C;
         5'd6:    op_char = 8'h5E;
         default: op_char = 8'h3F;
      endcase
   end

   always_comb begin
      // NOTE: every entry gets a default first so the variable-index writes below cannot infer latches.
      frame = '{default: 8'h00};
      if (dec_q) begin
         frame[0] = 8'h30 + s1_hun;
         frame[1] = 8'h30 + s1_ten;
         frame[2] = 8'h30 + s1_one;
         frame[3] = 8'h20;
         frame[4] = op_char;
         frame[5] = 8'h20;
         frame[6] = 8'h30 + s2_hun;
         frame[7] = 8'h30 + s2_ten;
         frame[8] = 8'h30 + s2_one;
         eol_pos  = 4'd9;
      end else begin
         frame[0] = hex_char(s1_q[7:4]);
         frame[1] = hex_char(s1_q[3:0]);
         frame[2] = 8'h20;
         frame[3] = op_char;
         frame[4] = 8'h20;
         frame[5] = hex_char(s2_q[7:4]);
         frame[6] = hex_char(s2_q[3:0]);
         eol_pos  = 4'd7;
      end
`ifdef CMD_ENCODER_CRLF_EN
      frame[eol_pos]        = 8'h0D;
      frame[eol_pos + 4'd1] = 8'h0A;
`else
      frame[eol_pos]        = 8'h0A;
`endif
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
         // NOTE: operand registers are reset too so uart_out is defined from the first cycle.
         s1_q    <= 8'h00;
         s2_q    <= 8'h00;
         op_q    <= 5'd0;
         dec_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req_valid && ready_q) begin
                  s1_q    <= bus.src1;
                  s2_q    <= bus.src2;
                  op_q    <= bus.operator;
                  dec_q   <= (bus.data_type == 4'd1);
                  idx_q   <= 4'd0;
                  valid_q <= 1'b1;
                  ready_q <= 1'b0;
                  state_q <= SEND;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            SEND: begin
               if (bus.uin_ready) begin
                  if (idx_q == last_idx) begin
                     idx_q   <= 4'd0;
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     idx_q <= idx_q + 4'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.uart_out   = valid_q ? frame[idx_q] : 8'h00;
   assign bus.uout_valid = valid_q;
   assign bus.req_ready  = ready_q;
   assign bus.cmd_done   = done_q;

endmodule

// File: tb/tb_cmd_encoder.sv
// Scoreboard bench for cmd_encoder: accepted requests push the expected ASCII
// frame (built from strings) into a queue that a negedge monitor drains.
module tb_cmd_encoder;

   typedef struct {
      logic [7:0] b;
      bit         last;
   } exp_t;

   logic clk;
   logic n_rst;
   cmd_encoder_if bus ();

   cmd_encoder u_dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   exp_t exp_q[$];
   bit   exp_done;
   int   accept_cnt;
   int   n_checks;
   int   n_pass;
   bit   uin_rand;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic string num_str(input logic [7:0] v, input bit dec);
      string s;
      if (dec) begin
         s = $sformatf("%0d", v);
         while (s.len() < 3) s = {"0", s};
      end else begin
         s = $sformatf("%h", v);
         s = s.toupper();
      end
      return s;
   endfunction

   function automatic void push_frame(input logic [7:0] a, input logic [7:0] b,
                                      input logic [4:0] op, input logic [3:0] dt);
      string ops = "+-*/&|^";
      string opc;
      string f;
      exp_t  e;
      bit    dec = (dt == 4'd1);
      opc = (op < 5'd7) ? ops.substr(int'(op), int'(op)) : "?";
      f = {num_str(a, dec), " ", opc, " ", num_str(b, dec)};
`ifdef CMD_ENCODER_CRLF_EN
      f = {f, "\r"};
`endif
      f = {f, "\n"};
      for (int i = 0; i < f.len(); i++) begin
         e.b    = f[i];
         e.last = (i == f.len() - 1);
         exp_q.push_back(e);
      end
   endfunction

   // Monitor: all output checks happen at negedge, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!n_rst) begin
            exp_q.delete();
            exp_done = 1'b0;
         end else begin
            check("uout_valid", {31'd0, bus.uout_valid}, {31'd0, exp_q.size() != 0});
            check("req_ready", {31'd0, bus.req_ready}, {31'd0, !(exp_q.size() != 0 || exp_done)});
            check("cmd_done", {31'd0, bus.cmd_done}, {31'd0, exp_done});
            exp_done = 1'b0;
            if (bus.uout_valid && exp_q.size() != 0) begin
               check("uart_out", {24'd0, bus.uart_out}, {24'd0, exp_q[0].b});
               if (bus.uin_ready) begin
                  exp_done = exp_q[0].last;
                  void'(exp_q.pop_front());
               end
            end
            if (bus.req_valid && bus.req_ready) begin
               push_frame(bus.src1, bus.src2, bus.operator, bus.data_type);
               accept_cnt++;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         if (uin_rand) begin
            #1;
            bus.uin_ready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   // Returns one tick after the accepting edge, when byte 0 is on uart_out.
   task automatic issue(input logic [7:0] a, input logic [7:0] b,
                        input logic [4:0] op, input logic [3:0] dt);
      bit got = 1'b0;
      @(posedge clk); #1;
      bus.src1      = a;
      bus.src2      = b;
      bus.operator  = op;
      bus.data_type = dt;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (bus.req_ready) got = 1'b1;
      end
      if (!got) check("accept_wait", {31'd0, bus.req_ready}, 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.src1      = 8'($urandom);
      bus.src2      = 8'($urandom);
      bus.operator  = 5'($urandom);
      bus.data_type = 4'($urandom);
   endtask

   task automatic wait_done();
      bit got = 1'b0;
      for (int i = 0; i < 600 && !got; i++) begin
         @(negedge clk);
         if (bus.cmd_done) got = 1'b1;
      end
      if (!got) check("cmd_done_wait", {31'd0, bus.cmd_done}, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      int base;
      bit got;
      n_checks      = 0;
      n_pass        = 0;
      accept_cnt    = 0;
      exp_done      = 1'b0;
      uin_rand      = 1'b0;
      bus.req_valid = 1'b0;
      bus.src1      = 8'h00;
      bus.src2      = 8'h00;
      bus.operator  = 5'd0;
      bus.data_type = 4'd0;
      bus.uin_ready = 1'b1;
      n_rst         = 1'b1;
      #1 n_rst = 1'b0;
      #2;
      check("rst_uout_valid", {31'd0, bus.uout_valid}, 32'd0);
      check("rst_uart_out", {24'd0, bus.uart_out}, 32'd0);
      check("rst_cmd_done", {31'd0, bus.cmd_done}, 32'd0);
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk); #2 n_rst = 1'b1;
      #1 check("ready_before_edge", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
      check("ready_after_release", {31'd0, bus.req_ready}, 32'd1);

      // Hex frame at full rate, then a decimal frame.
      issue(8'h3A, 8'h05, 5'd0, 4'd0);
      wait_done();
      issue(8'd255, 8'd7, 5'd2, 4'd1);
      wait_done();
      // Unknown operator with a non-1 radix code stays hex.
      issue(8'hC4, 8'h9F, 5'd31, 4'd9);
      wait_done();

      // Stall on byte 4 (0x2B) for 5 cycles.
      issue(8'h3A, 8'h05, 5'd0, 4'd0);
      repeat (3) @(posedge clk);
      #1 bus.uin_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("stall_byte", {24'd0, bus.uart_out}, 32'h2B);
         check("stall_valid", {31'd0, bus.uout_valid}, 32'd1);
      end
      @(posedge clk); #1 bus.uin_ready = 1'b1;
      wait_done();

      // Held request across two commands.
      @(posedge clk); #1;
      bus.src1      = 8'h12;
      bus.src2      = 8'd200;
      bus.operator  = 5'd6;
      bus.data_type = 4'd1;
      bus.req_valid = 1'b1;
      base = accept_cnt;
      got  = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(posedge clk);
         if (accept_cnt >= base + 2) got = 1'b1;
      end
      if (!got) check("hold_accepts", accept_cnt, base + 2);
      #1 bus.req_valid = 1'b0;
      wait_done();

      // Reset in the middle of a frame, then a fresh command.
      issue(8'hAB, 8'hCD, 5'd4, 4'd0);
      repeat (2) @(posedge clk);
      #3 n_rst = 1'b0;
      #1;
      check("midrst_uout_valid", {31'd0, bus.uout_valid}, 32'd0);
      check("midrst_uart_out", {24'd0, bus.uart_out}, 32'd0);
      check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk); #2 n_rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_ready_after", {31'd0, bus.req_ready}, 32'd1);
      issue(8'h01, 8'hFE, 5'd5, 4'd1);
      wait_done();

      // Randomized commands with random downstream back-pressure.
      uin_rand = 1'b1;
      repeat (25) begin
         issue(8'($urandom), 8'($urandom), 5'($urandom),
               ($urandom_range(0, 1) != 0) ? 4'd1 : 4'($urandom));
         if ($urandom_range(0, 1) != 0) wait_done();
      end
      wait_done();
      uin_rand = 1'b0;
      @(posedge clk); #1 bus.uin_ready = 1'b1;
      repeat (20) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
